mem_ctrl: RTL and testbench

- Byte-wide RAM port controller and arbiter between the IF stage (instruction word fetch) and the MEM stage (load/store, 1/2/4 bytes).
- Owns the single 8-bit CPU–RAM port. It serialises each request into byte accesses and returns assembled little-endian words with a one-cycle done pulse.
- Requesters no longer step through per-byte FSMs themselves. MEM performs its own sign/zero extension of load results.

---
 rtl/mem_ctrl_pkg.sv | 24 ++
 rtl/mem_ctrl_ram_byte_seq.sv | 113 +++++++++++
 rtl/mem_ctrl.sv | 95 +++++++++
 tb/tb_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-wide RAM port controller: access size
// encodings, sequencer state codes and the size-to-byte-count helper.
package mem_ctrl_pkg;

    localparam logic [1:0] MEM_SZ_B = 2'b00;
    localparam logic [1:0] MEM_SZ_H = 2'b01;
    localparam logic [1:0] MEM_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } seqState_e;

    // Both 2'b10 and 2'b11 select a full word.
    function automatic logic [2:0] sizeToCount(input logic [1:0] size);
        case (size)
            MEM_SZ_B: return 3'd1;
            MEM_SZ_H: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_ram_byte_seq.sv
// Byte issue/capture engine: walks base..base+n-1 on the RAM port, either
// writing store bytes or assembling read bytes into a little-endian word.
module mem_ctrl_ram_byte_seq
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_we,
    input  logic [2:0]        i_n,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [31:0]       i_wdata,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_finish,
    output logic [31:0]       o_rdata,
    output logic [ADDR_W-1:0] o_ram_a,
    output logic [7:0]        o_ram_dout,
    output logic              o_ram_wr,
    input  logic [7:0]        i_ram_din
);

    localparam int CNT_W = $clog2(RD_LAT + 5) + 1;

    seqState_e         r_state;
    seqState_e         w_nextState;
    logic [ADDR_W-1:0] r_base;
    logic [2:0]        r_n;
    logic [31:0]       r_wdata;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_wrLast;
    logic [CNT_W-1:0]  w_rdLast;
    logic              w_issue;
    logic              w_capture;
    logic [1:0]        w_capIdx;
    logic [ADDR_W-1:0] w_issueAddr;

    // r_cnt is the offset from the accept edge of the edge about to happen.
    assign w_wrLast    = CNT_W'(r_n);
    assign w_rdLast    = CNT_W'(r_n) + CNT_W'(RD_LAT) - CNT_W'(1);
    assign w_issue     = r_cnt < w_wrLast;
    assign w_capture   = (r_cnt >= CNT_W'(RD_LAT)) && (r_cnt <= w_rdLast);
    assign w_capIdx    = 2'(r_cnt - CNT_W'(RD_LAT));
    assign w_issueAddr = r_base + ADDR_W'(r_cnt);

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (i_start) w_nextState = i_we ? ST_WR : ST_RD;
            ST_RD:   if (i_abort || (r_cnt == w_rdLast)) w_nextState = ST_IDLE;
            ST_WR:   if (r_cnt == w_wrLast) w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (r_state != ST_IDLE);
        o_finish = ((r_state == ST_RD) && (r_cnt == w_rdLast) && !i_abort) ||
                   ((r_state == ST_WR) && (r_cnt == w_wrLast));
    end

    // Byte 0 goes out on the accept edge itself; an abort freezes the port.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_base     <= '0;
            r_n        <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            o_rdata    <= '0;
            o_ram_a    <= '0;
            o_ram_dout <= '0;
            o_ram_wr   <= 1'b0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_base  <= i_base;
            r_n     <= i_n;
            r_wdata <= i_wdata;
            r_cnt   <= CNT_W'(1);
            o_rdata <= '0;
            o_ram_a <= i_base;
            o_ram_wr <= i_we;
            if (i_we) begin
                o_ram_dout <= i_wdata[7:0];
            end
        end else if ((r_state != ST_IDLE) && !i_abort) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_issue) begin
                o_ram_a <= w_issueAddr;
                if (r_state == ST_WR) begin
                    o_ram_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                end
            end
            if ((r_state == ST_WR) && (r_cnt == w_wrLast)) begin
                o_ram_wr <= 1'b0;
            end
            if ((r_state == ST_RD) && w_capture) begin
                o_rdata[{w_capIdx, 3'b000} +: 8] <= i_ram_din;
            end
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// RAM port arbiter between instruction fetch and load/store: MEM wins ties,
// flush cancels fetches, and completion is routed back as one-cycle pulses.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_done,
    output logic [31:0]       o_if_rdata,
    input  logic              i_mem_req,
    input  logic              i_mem_we,
    input  logic [1:0]        i_mem_size,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [31:0]       i_mem_wdata,
    output logic              o_mem_done,
    output logic [31:0]       o_mem_rdata,
    output logic [ADDR_W-1:0] o_ram_a,
    output logic [7:0]        o_ram_dout,
    output logic              o_ram_wr,
    input  logic [7:0]        i_ram_din
);

    logic              r_ownerMem;
    logic              r_ifDone;
    logic              r_memDone;

    logic              w_busy;
    logic              w_finish;
    logic              w_acceptMem;
    logic              w_acceptIf;
    logic              w_start;
    logic              w_we;
    logic [2:0]        w_n;
    logic [ADDR_W-1:0] w_base;
    logic              w_abort;
    logic [31:0]       w_rdata;

    // A port whose done is still high is not re-accepted this cycle.
    always_comb begin
        w_acceptMem = !w_busy && i_mem_req && !r_memDone;
        w_acceptIf  = !w_busy && !w_acceptMem && i_if_req && !r_ifDone && !i_flush;
        w_start     = w_acceptMem || w_acceptIf;
        w_we        = w_acceptMem && i_mem_we;
        w_n         = w_acceptMem ? sizeToCount(i_mem_size) : 3'd4;
        w_base      = w_acceptMem ? i_mem_addr : i_if_addr;
        w_abort     = i_flush && w_busy && !r_ownerMem;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ownerMem <= 1'b0;
            r_ifDone   <= 1'b0;
            r_memDone  <= 1'b0;
        end else begin
            if (w_start) begin
                r_ownerMem <= w_acceptMem;
            end
            r_ifDone  <= w_finish && !r_ownerMem;
            r_memDone <= w_finish && r_ownerMem;
        end
    end

    mem_ctrl_ram_byte_seq #(
        .RD_LAT (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_seq (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_start),
        .i_we       (w_we),
        .i_n        (w_n),
        .i_base     (w_base),
        .i_wdata    (i_mem_wdata),
        .i_abort    (w_abort),
        .o_busy     (w_busy),
        .o_finish   (w_finish),
        .o_rdata    (w_rdata),
        .o_ram_a    (o_ram_a),
        .o_ram_dout (o_ram_dout),
        .o_ram_wr   (o_ram_wr),
        .i_ram_din  (i_ram_din)
    );

    assign o_if_done   = r_ifDone;
    assign o_mem_done  = r_memDone;
    assign o_if_rdata  = w_rdata;
    assign o_mem_rdata = w_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: a byte RAM with RD_LAT read pipeline on the port and a
// separate reference byte array updated from completed stores.
module tb_mem_ctrl;

    localparam int RD_LAT = 2;

    logic        clock = 1'b0;
    logic        rstN;
    logic        flush;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic        ifDone;
    logic [31:0] ifRdata;
    logic        memReq;
    logic        memWe;
    logic [1:0]  memSize;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic        memDone;
    logic [31:0] memRdata;
    logic [31:0] ramA;
    logic [7:0]  ramDout;
    logic        ramWr;
    logic [7:0]  ramDin = 8'h00;

    logic [7:0]  devMem [0:65535];
    logic [7:0]  refMem [0:65535];
    logic [31:0] addrHist [0:RD_LAT-1] = '{default: 32'h0};
    logic [31:0] lastAddr;
    int          testCount = 0;
    int          failCount = 0;

    mem_ctrl #(
        .RD_LAT (RD_LAT),
        .ADDR_W (32)
    ) dut (
        .i_clk       (clock),
        .i_rst       (rstN),
        .i_flush     (flush),
        .i_if_req    (ifReq),
        .i_if_addr   (ifAddr),
        .o_if_done   (ifDone),
        .o_if_rdata  (ifRdata),
        .i_mem_req   (memReq),
        .i_mem_we    (memWe),
        .i_mem_size  (memSize),
        .i_mem_addr  (memAddr),
        .i_mem_wdata (memWdata),
        .o_mem_done  (memDone),
        .o_mem_rdata (memRdata),
        .o_ram_a     (ramA),
        .o_ram_dout  (ramDout),
        .o_ram_wr    (ramWr),
        .i_ram_din   (ramDin)
    );

    always #5 clock = ~clock;

    // RAM device: writes land as presented; read data for an address appears
    // RD_LAT edges after that address was registered.
    always @(posedge clock) begin
        #1;
        for (int k = RD_LAT - 1; k > 0; k--) addrHist[k] = addrHist[k-1];
        addrHist[0] = ramA;
        if (ramWr) devMem[ramA[15:0]] = ramDout;
        ramDin = devMem[addrHist[RD_LAT-1][15:0]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int byteCount(input logic [1:0] size);
        case (size)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] addr, input int n);
        logic [31:0] a;
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            w[8*i +: 8] = refMem[a[15:0]];
        end
        return w;
    endfunction

    task automatic refStore(input logic [31:0] addr, input int n, input logic [31:0] wdata);
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            a = addr + 32'(i);
            refMem[a[15:0]] = wdata[8*i +: 8];
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [7:0] value);
        devMem[addr[15:0]] = value;
        refMem[addr[15:0]] = value;
    endtask

    // One transaction on one port; flushCyc >= 1 pulses flush so that it is
    // sampled at edge E0+flushCyc (an IF transaction is then expected to die).
    task automatic applyStimulus(input bit isIf, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata, input int flushCyc);
        int          n;
        int          lat;
        int          doneAt;
        bit          flushing;
        logic        done;
        logic [31:0] expData;
        logic [31:0] gotData;
        string       who;
        n        = isIf ? 4 : byteCount(size);
        lat      = we ? n : n - 1 + RD_LAT;
        flushing = isIf && (flushCyc >= 0);
        who      = isIf ? "if" : "mem";
        expData  = refWord(addr, n);
        gotData  = '0;
        doneAt   = -1;
        @(negedge clock);
        if (isIf) begin
            ifReq = 1'b1; ifAddr = addr;
        end else begin
            memReq = 1'b1; memWe = we; memSize = size; memAddr = addr; memWdata = wdata;
        end
        for (int c = 0; c <= lat + 2; c++) begin
            @(posedge clock); #1;
            if (c < n && !(flushing && c >= flushCyc)) checkOutput({who, "RamAddr"}, ramA, addr + 32'(c));
            if (we && c < n) checkOutput("ramWrite", {23'b0, ramWr, ramDout}, {23'b0, 1'b1, wdata[8*c +: 8]});
            if (we && c == n) checkOutput("ramWrOff", 32'(ramWr), 32'd0);
            done = isIf ? ifDone : memDone;
            if (done && doneAt < 0) begin
                doneAt  = c;
                gotData = isIf ? ifRdata : memRdata;
                if (!we) checkOutput({who, "RamAddrHold"}, ramA, addr + 32'(n - 1));
            end
            if (flushCyc >= 0 && c == flushCyc - 1) flush = 1'b1;
            if (c == flushCyc) flush = 1'b0;
            if (flushing && c == flushCyc) break;
            if (doneAt >= 0) break;
        end
        flush = 1'b0;
        if (isIf) ifReq = 1'b0; else memReq = 1'b0;
        if (flushing) begin
            checkOutput("flushNoIfDone", 32'(doneAt >= 0), 32'd0);
            return;
        end
        checkOutput({who, "Latency"}, 32'(doneAt), 32'(lat));
        if (!we) checkOutput({who, "Rdata"}, gotData, expData);
        @(posedge clock); #1;
        checkOutput({who, "DonePulse"}, 32'(isIf ? ifDone : memDone), 32'd0);
        if (we) refStore(addr, n, wdata);
        lastAddr = addr + 32'(n - 1);
    endtask

    // MEM and IF raised together: MEM must finish first, IF one edge later.
    task automatic applyContention(input bit we, input logic [1:0] size, input logic [31:0] mAddr,
                                   input logic [31:0] wdata, input logic [31:0] fAddr);
        int          n;
        int          memLat;
        int          memAt;
        int          ifAt;
        logic [31:0] expMem;
        logic [31:0] gotMem;
        logic [31:0] gotIf;
        n      = byteCount(size);
        memLat = we ? n : n - 1 + RD_LAT;
        expMem = refWord(mAddr, n);
        memAt  = -1; ifAt = -1; gotMem = '0; gotIf = '0;
        @(negedge clock);
        ifReq  = 1'b1; ifAddr = fAddr;
        memReq = 1'b1; memWe = we; memSize = size; memAddr = mAddr; memWdata = wdata;
        for (int c = 0; c < 60; c++) begin
            @(posedge clock); #1;
            if (memDone && memAt < 0) begin memAt = c; gotMem = memRdata; memReq = 1'b0; end
            if (ifDone && ifAt < 0) begin ifAt = c; gotIf = ifRdata; ifReq = 1'b0; end
            if (ifAt >= 0) break;
        end
        memReq = 1'b0; ifReq = 1'b0;
        if (we) refStore(mAddr, n, wdata);
        checkOutput("arbMemLatency", 32'(memAt), 32'(memLat));
        checkOutput("arbIfLatency", 32'(ifAt), 32'(memLat + 4 + RD_LAT));
        if (!we) checkOutput("arbMemRdata", gotMem, expMem);
        checkOutput("arbIfRdata", gotIf, refWord(fAddr, 4));
        @(posedge clock); #1;
        checkOutput("arbDoneClear", {30'b0, ifDone, memDone}, 32'd0);
        lastAddr = fAddr + 32'd3;
    endtask

    function automatic logic [31:0] randAddr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'h0000_4000 + 32'($urandom_range(0, 255));
    endfunction

    initial begin
        logic [7:0]  kept;
        logic [31:0] v;
        rstN = 1'b0; flush = 1'b0; ifReq = 1'b0; ifAddr = '0;
        memReq = 1'b0; memWe = 1'b0; memSize = 2'b00; memAddr = '0; memWdata = '0;
        for (int i = 0; i < 65536; i++) begin
            v = $urandom;
            devMem[i] = v[7:0];
            refMem[i] = v[7:0];
        end
        preload(32'h100, 8'h13); preload(32'h101, 8'h05); preload(32'h102, 8'h10); preload(32'h103, 8'h00);
        preload(32'h2003, 8'hF0);
        preload(32'h3002, 8'h77);

        repeat (3) @(posedge clock);
        #1;
        checkOutput("rstRamA", ramA, 32'd0);
        checkOutput("rstRamCtl", {23'b0, ramWr, ramDout}, 32'd0);
        checkOutput("rstDones", {30'b0, ifDone, memDone}, 32'd0);
        checkOutput("rstRdata", memRdata, 32'd0);
        checkOutput("rstIfRdata", ifRdata, 32'd0);
        @(negedge clock);
        rstN = 1'b1;

        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, -1);
        checkOutput("fetchWord", refWord(32'h100, 4), 32'h0010_0513);
        applyStimulus(1'b0, 1'b0, 2'b00, 32'h2003, 32'h0, -1);
        kept = refMem[16'h3002];
        applyStimulus(1'b0, 1'b1, 2'b01, 32'h3000, 32'hDEAD_BEEF, -1);
        checkOutput("ram3002Kept", {24'b0, devMem[16'h3002]}, {24'b0, kept});
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h3000, 32'h0, -1);
        applyContention(1'b0, 2'b10, 32'h2000, 32'h0, 32'h100);
        applyContention(1'b1, 2'b10, 32'h104, 32'h1234_5678, 32'h104);

        applyStimulus(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, -1);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h104, 32'h0, 3 + RD_LAT);
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h200, 32'h0, -1);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h2000, 32'h0, 2);

        flush = 1'b1; ifReq = 1'b1; ifAddr = 32'h500;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("flushBlocksIf", ramA, lastAddr);
        checkOutput("flushBlocksDone", 32'(ifDone), 32'd0);
        flush = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b10, 32'h500, 32'h0, -1);

        applyStimulus(1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'hCAFE_F00D, -1);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0, -1);

        preload(32'h6000, 8'h11); preload(32'h6001, 8'h22); preload(32'h6002, 8'h33); preload(32'h6003, 8'h44);
        @(negedge clock);
        memReq = 1'b1; memWe = 1'b1; memSize = 2'b10; memAddr = 32'h6000; memWdata = 32'hA1B2_C3D4;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        rstN = 1'b0;
        @(posedge clock); #1;
        memReq = 1'b0;
        checkOutput("midRstRamCtl", {23'b0, ramWr, ramDout}, 32'd0);
        checkOutput("midRstRamA", ramA, 32'd0);
        checkOutput("midRstDones", {30'b0, ifDone, memDone}, 32'd0);
        checkOutput("midRstRdata", memRdata, 32'd0);
        @(negedge clock);
        rstN = 1'b1;
        refStore(32'h6000, 2, 32'h0000_C3D4);
        applyStimulus(1'b0, 1'b0, 2'b10, 32'h6000, 32'h0, -1);
        checkOutput("midRstPartial", refWord(32'h6000, 4), 32'h4433_C3D4);

        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            if (kind <= 3) begin
                if ($urandom_range(0, 3) == 0)
                    applyStimulus(1'b1, 1'b0, 2'b10, randAddr(), 32'h0, $urandom_range(1, 3 + RD_LAT));
                applyStimulus(1'b1, 1'b0, 2'b10, randAddr(), 32'h0, -1);
            end else if (kind <= 8) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), randAddr(), $urandom, -1);
            end else begin
                applyContention(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), randAddr(), $urandom, randAddr());
            end
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
